// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a load/store into a req/ack bus transaction,
// formats load data for MEM/WB, and stalls the pipeline until the access completes.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t        state, stateNext;
  logic [CW-1:0] cnt;
  logic [2:0]    f3Lat;
  logic [1:0]    laneLat;
  logic          isLoad;
  logic          faultPend;
  logic          attempt, access, legalF3, aligned, legal, timeoutHit;

  function automatic logic [31:0] fmtLoad(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] storeStrb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Request decode: both read and write asserted is an illegal access.
  always_comb begin
    attempt = MemReadM | MemWriteM;
    access  = MemReadM ^ MemWriteM;
    if (MemWriteM)
      legalF3 = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    else
      legalF3 = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                (funct3M == 3'b100) || (funct3M == 3'b101);
    case (funct3M[1:0])
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal      = access && legalF3 && aligned;
    timeoutHit = (TIMEOUT_CYCLES != 0) && ((32'(cnt) + 32'd1) == TIMEOUT_CYCLES);
  end

  always_comb begin
    stateNext = state;
    StallM    = 1'b0;
    FaultM    = 1'b0;
    case (state)
      IDLE: begin
        if (attempt && !legal) begin
          FaultM = 1'b1;
        end else if (legal) begin
          StallM    = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        // An ack in the final allowed cycle wins over the timeout.
        if (mem_ack || timeoutHit) stateNext = DONE;
      end
      DONE: begin
        FaultM    = faultPend;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3Lat     <= 3'b000;
      laneLat   <= 2'b00;
      isLoad    <= 1'b0;
      faultPend <= 1'b0;
      ReadDataM <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (legal) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wstrb <= MemWriteM ? storeStrb(funct3M, ALUResultM[1:0]) : 4'b0000;
            mem_wdata <= MemWriteM ? storeData(funct3M, WriteDataM) : 32'h0;
            f3Lat     <= funct3M;
            laneLat   <= ALUResultM[1:0];
            isLoad    <= MemReadM;
            cnt       <= '0;
            faultPend <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (mem_ack) begin
            mem_req   <= 1'b0;
            faultPend <= mem_err;
            if (isLoad) ReadDataM <= mem_err ? 32'h0 : fmtLoad(f3Lat, laneLat, mem_rdata);
          end else if (timeoutHit) begin
            mem_req   <= 1'b0;
            faultPend <= 1'b1;
            if (isLoad) ReadDataM <= 32'h0;
          end
        end
        DONE:    faultPend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of load/store vectors plus reset and stray-ack sequences.
module tb_mem_stage_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack, mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          waits;
    logic        err;
    logic [31:0] expRead;
    logic        expFault;
    int          expStall;
    logic [31:0] expAddr, expWdata;
    logic [3:0]  expWstrb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] rdata, int waits, logic err,
                              logic [31:0] expRead, logic expFault, int expStall,
                              logic [31:0] expAddr, logic [31:0] expWdata, logic [3:0] expWstrb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.waits = waits; v.err = err; v.expRead = expRead; v.expFault = expFault;
    v.expStall = expStall; v.expAddr = expAddr; v.expWdata = expWdata; v.expWstrb = expWstrb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    int stall, busy, faults;
    bit sawReq, done;
    stall = 0; busy = 0; faults = 0; sawReq = 0; done = 0;
    @(negedge clock);
    MemReadM = v.rd; MemWriteM = v.wr; funct3M = v.f3; ALUResultM = v.addr; WriteDataM = v.wd;
    #1;
    if (v.expStall == 0) begin
      chk($sformatf("v%0d fault_pulse", idx), 32'(FaultM), 32'd1);
      chk($sformatf("v%0d stall_illegal", idx), 32'(StallM), 32'd0);
      @(posedge clock); #1;
      chk($sformatf("v%0d no_req", idx), 32'(mem_req), 32'd0);
      idleInputs();
      #1;
      chk($sformatf("v%0d fault_clear", idx), 32'(FaultM), 32'd0);
      chk($sformatf("v%0d rdata_hold", idx), ReadDataM, v.expRead);
      return;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (StallM) stall++;
      if (FaultM) faults++;
      if (mem_req) begin
        if (!sawReq) begin
          sawReq = 1;
          chk($sformatf("v%0d mem_addr", idx), mem_addr, v.expAddr);
          chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.wr));
          chk($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.expWstrb));
          if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.expWdata);
        end
        if (busy == v.waits) begin
          mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
        end
        busy++;
      end
      if (c > 0 && !StallM) begin
        done = 1;
      end else begin
        @(negedge clock);
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        #1;
      end
    end
    chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall), 32'(v.expStall));
    chk($sformatf("v%0d busy_cycles", idx), 32'(busy), 32'(v.expStall - 1));
    chk($sformatf("v%0d fault_count", idx), 32'(faults), 32'(v.expFault));
    chk($sformatf("v%0d ReadDataM", idx), ReadDataM, v.expRead);
    chk($sformatf("v%0d req_dropped", idx), 32'(mem_req), 32'd0);
    idleInputs();
    @(negedge clock); #1;
    chk($sformatf("v%0d idle_after", idx), 32'({StallM, FaultM}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idleInputs();
    mem_rdata = 32'h0; mem_ack = 1'b0; mem_err = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst ReadDataM", ReadDataM, 32'h0);
    chk("rst ctrl", 32'({mem_req, mem_we, StallM, FaultM}), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back(mk(1,0,3'b010,32'h100,32'h0,32'hDEADBEEF,0,0,32'hDEADBEEF,0,2,32'h100,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b000,32'h203,32'h0,32'h80FF0000,0,0,32'hFFFFFF80,0,2,32'h200,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b100,32'h203,32'h0,32'h80FF0000,0,0,32'h00000080,0,2,32'h200,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b000,32'h203,32'h0,32'h80FF0000,3,0,32'hFFFFFF80,0,5,32'h200,32'h0,4'b0000));
    vecs.push_back(mk(0,1,3'b000,32'h002,32'h123456AB,32'h0,0,0,32'hFFFFFF80,0,2,32'h0,32'hABABABAB,4'b0100));
    vecs.push_back(mk(0,1,3'b001,32'h006,32'h0000BEEF,32'h0,1,0,32'hFFFFFF80,0,3,32'h4,32'hBEEFBEEF,4'b1100));
    vecs.push_back(mk(1,0,3'b001,32'h102,32'h0,32'h80011234,0,0,32'hFFFF8001,0,2,32'h100,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b101,32'h102,32'h0,32'h80011234,0,0,32'h00008001,0,2,32'h100,32'h0,4'b0000));
    vecs.push_back(mk(0,1,3'b010,32'h040,32'hCAFEF00D,32'h0,0,0,32'h00008001,0,2,32'h40,32'hCAFEF00D,4'b1111));
    vecs.push_back(mk(1,0,3'b010,32'h101,32'h0,32'h0,0,0,32'h00008001,1,0,32'h0,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b011,32'h100,32'h0,32'h0,0,0,32'h00008001,1,0,32'h0,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b001,32'h103,32'h0,32'h0,0,0,32'h00008001,1,0,32'h0,32'h0,4'b0000));
    vecs.push_back(mk(1,1,3'b010,32'h100,32'h0,32'h0,0,0,32'h00008001,1,0,32'h0,32'h0,4'b0000));
    vecs.push_back(mk(0,1,3'b100,32'h100,32'h0,32'h0,0,0,32'h00008001,1,0,32'h0,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b010,32'h200,32'h0,32'h0,1000,0,32'h0,1,5,32'h200,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b010,32'h300,32'h0,32'h11223344,1,1,32'h0,1,3,32'h300,32'h0,4'b0000));
    vecs.push_back(mk(1,0,3'b010,32'h300,32'h0,32'h11223344,0,0,32'h11223344,0,2,32'h300,32'h0,4'b0000));

    foreach (vecs[i]) runVec(vecs[i], i);

    // Stray ack while idle must not disturb load data.
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("stray_ack ReadDataM", ReadDataM, 32'h11223344);
    chk("stray_ack ctrl", 32'({mem_req, StallM, FaultM}), 32'd0);

    // Reset one cycle into BUSY aborts the transaction.
    @(negedge clock);
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h100;
    @(posedge clock); #1;
    chk("midrst req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst req_after", 32'(mem_req), 32'd0);
    chk("midrst mem_addr", mem_addr, 32'h0);
    chk("midrst ReadDataM", ReadDataM, 32'h0);
    idleInputs();
    #1;
    chk("midrst idle_state", 32'(StallM), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    runVec(mk(1,0,3'b010,32'h100,32'h0,32'h0BADF00D,0,0,32'h0BADF00D,0,2,32'h100,32'h0,4'b0000), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and reg_MEM_WB.
- Turns MemReadM/MemWriteM plus funct3M into a req/ack transaction on the data-memory bus.
- Formats and sign-extends load data into ReadDataM for the MEM/WB register.
- Raises StallM, which holds the PC, IF/ID, ID/EX and EX/MEM registers and deasserts reg_MEM_WB enable, until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for mem_ack before fault; 0 disables timeout.

Ports:
clock  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
MemReadM  in  1  load in MEM stage
MemWriteM  in  1  store in MEM stage
funct3M  in  3  RV32I load/store width/sign code
ALUResultM  in  32  byte address
WriteDataM  in  32  store data (rs2)
ReadDataM  out  32  formatted load data to reg_MEM_WB
StallM  out  1  freeze upstream stages, disable MEM/WB capture
FaultM  out  1  one-cycle pulse: misaligned, illegal funct3, timeout, or bus error
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write
mem_addr  out  32  word address; ALUResultM with bits [1:0] forced to 0
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables; 0000 for reads
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion
mem_err  in  1  bus error, sampled only with mem_ack

Behaviour:
- Reset values: state IDLE; ReadDataM = 0, FaultM = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
- Reset mid-transaction aborts it: mem_req drops immediately and the FSM returns to IDLE.
- Access is MemReadM xor MemWriteM. Both asserted is illegal.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Alignment rules: halfword needs addr[0] = 0; word needs addr[1:0] = 00.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No access: StallM = 0, stay in IDLE.
  - Illegal or misaligned access: no bus activity, FaultM = 1 for that cycle, StallM = 0, ReadDataM unchanged, stay in IDLE.
  - Legal access: StallM = 1 (combinational). On the next edge latch address, we, wstrb, wdata and funct3, set mem_req = 1, clear the timeout counter, and go to BUSY.
- BUSY:
  - StallM = 1. mem_req and all latched bus fields stay stable until ack.
  - Counter increments each cycle.
  - On mem_ack: drop mem_req and go to DONE. For a load, ReadDataM is updated at the same edge. If mem_err is also high, FaultM pulses in DONE and ReadDataM = 0.
  - Timeout (TIMEOUT_CYCLES != 0, counter reaches TIMEOUT_CYCLES with no ack): drop mem_req, go to DONE, FaultM pulses in DONE, ReadDataM = 0.
- DONE: StallM = 0 for exactly one cycle so the pipeline advances and reg_MEM_WB captures ReadDataM. Always go to IDLE; the instruction now in MEM is a new one.
- Latency: zero-wait memory (ack the cycle after req) gives 3 cycles in MEM, 2 of them stalled. Each memory wait state adds 1 cycle.
- Store formatting:
  - SB: wdata = {4{WriteDataM[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{WriteDataM[15:0]}}, wstrb = 0011 if addr[1] = 0, else 1100.
  - SW: wdata = WriteDataM, wstrb = 1111.
- Load formatting:
  - Select the byte/half lane from mem_rdata using the latched addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes mem_rdata through.
- ReadDataM holds its value through stores and non-memory instructions.
- mem_ack outside BUSY is ignored.

Test Plan:
- LW addr 0x100, memory acks 1 cycle after req with 0xDEADBEEF -> StallM high 2 cycles, ReadDataM = 0xDEADBEEF, FaultM stays 0.
- LB addr 0x203, rdata 0x80FF_0000 -> ReadDataM = 0xFFFFFF80; LBU at the same address -> 0x00000080. Repeat with 3 wait states -> StallM high 5 cycles.
- SB addr 0x0002, WriteDataM 0x123456AB -> mem_we = 1, mem_addr = 0x0000, wstrb = 0100, wdata = 0xABABABAB. SH addr 0x6 -> wstrb = 1100.
- LW addr 0x101 and funct3 = 011 -> no mem_req, FaultM one-cycle pulse, StallM = 0.
- TIMEOUT_CYCLES = 4, memory never acks -> mem_req drops after 4 BUSY cycles, FaultM pulses, ReadDataM = 0, pipeline resumes. Ack with mem_err = 1 -> same fault response.
- Assert reset 1 cycle into BUSY -> mem_req = 0 and state IDLE immediately; after release, a new LW completes normally.
